// File: rtl/opentdc_pkg.sv
// Shared constants and types for the multi-channel TDC Wishbone slave.
package opentdc_pkg;

  localparam int NCH_MAX = 8;
  localparam int CHAN_W  = 3;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_TIME      = 3'd2;
  localparam logic [2:0] REG_EVT_TAG   = 3'd3;
  localparam logic [2:0] REG_EVT_TS    = 3'd4;
  localparam logic [2:0] REG_OUT_TIME  = 3'd5;
  localparam logic [2:0] REG_OUT_WIDTH = 3'd6;

  localparam int CTRL_EN_LSB   = 0;
  localparam int CTRL_FALL_LSB = 8;
  localparam int CTRL_OUT_EN   = 16;
  localparam int CTRL_RUN      = 17;

  typedef enum logic [1:0] {P_IDLE, P_ARMED, P_PULSE} pulse_state_t;

endpackage

// File: rtl/opentdc_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO or a pop from an empty one is ignored.
module opentdc_evt_fifo
  import opentdc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = CHAN_W + 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/opentdc_mc_wb.sv
// Multi-channel TDC: synchronised edge capture against a coarse counter, shared event FIFO,
// programmable-delay pulse output, all behind a single-cycle-ack Wishbone register file.
module opentdc_mc_wb
  import opentdc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [NCH-1:0]  inp_i,
  input  logic            rst_time_n_i,
  output logic            out0_o,
  output logic            oen_o
);

  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = CHAN_W + TS_W;

  logic [NCH-1:0]    en, fall, ovf, in_s1, in_s2, in_d, det, pend_v, grant;
  logic [TS_W-1:0]   pend_ts [NCH];
  logic              out_en, run, rt_s1, rt_s2;
  logic [TS_W-1:0]   time_q, out_time, push_ts;
  logic [7:0]        out_width, cnt, cnt_n;
  logic [CHAN_W-1:0] push_chan;
  logic [DATA_W-1:0] fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty, push, pop;
  logic              req, wr, rd;
  logic [2:0]        adr_w;
  logic [31:0]       rd_data;
  pulse_state_t      pulse_state, pulse_state_n;
  logic              unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i};

  // A request is stb & cyc with no ack outstanding; it is accepted on that edge and
  // acked for exactly one cycle with read data, so back-to-back requests alternate.
  assign req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr    = req & wbs_we_i;
  assign rd    = req & ~wbs_we_i;
  assign adr_w = wbs_adr_i[4:2];
  assign pop   = rd & (adr_w == REG_EVT_TS);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rd_data : '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      en <= '0; fall <= '0; out_en <= 1'b0; run <= 1'b0;
      out_time <= '0; out_width <= '0;
    end else if (wr) begin
      case (adr_w)
        REG_CTRL: begin
          en     <= wbs_dat_i[CTRL_EN_LSB +: NCH];
          fall   <= wbs_dat_i[CTRL_FALL_LSB +: NCH];
          out_en <= wbs_dat_i[CTRL_OUT_EN];
          run    <= wbs_dat_i[CTRL_RUN];
        end
        REG_OUT_TIME:  out_time  <= wbs_dat_i[TS_W-1:0];
        REG_OUT_WIDTH: out_width <= wbs_dat_i[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      rt_s1 <= 1'b0; rt_s2 <= 1'b0; time_q <= '0;
      in_s1 <= '0; in_s2 <= '0; in_d <= '0;
    end else begin
      rt_s1 <= rst_time_n_i;
      rt_s2 <= rt_s1;
      if (!rt_s2)   time_q <= '0;
      else if (run) time_q <= time_q + 1'b1;
      in_s1 <= inp_i;
      in_s2 <= in_s1;
      in_d  <= in_s2;
    end
  end

  assign det = en & ((fall & in_d & ~in_s2) | (~fall & in_s2 & ~in_d));

  // A detection against an occupied slot is dropped and flagged; the set beats a W1C clear.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      pend_v <= '0;
      ovf    <= '0;
      for (int c = 0; c < NCH; c++) pend_ts[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (grant[c]) pend_v[c] <= 1'b0;
        if (det[c] && !pend_v[c]) begin
          pend_v[c]  <= 1'b1;
          pend_ts[c] <= time_q;
        end
      end
      ovf <= (ovf & ~((wr && adr_w == REG_STATUS) ? wbs_dat_i[NCH-1:0] : '0)) | (det & pend_v);
    end
  end

  // Lowest-indexed pending slot wins; descending loop leaves the lowest as last write.
  always_comb begin
    grant     = '0;
    push_chan = '0;
    push_ts   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend_v[c]) begin
        grant     = '0;
        grant[c]  = 1'b1;
        push_chan = CHAN_W'(c);
        push_ts   = pend_ts[c];
      end
    end
    if (fifo_full) grant = '0;
  end

  assign push = |grant;

  opentdc_evt_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (push),
    .pop   (pop),
    .din   ({push_chan, push_ts}),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      pulse_state <= P_IDLE;
      cnt         <= '0;
    end else begin
      pulse_state <= pulse_state_n;
      cnt         <= cnt_n;
    end
  end

  always_comb begin
    pulse_state_n = pulse_state;
    cnt_n         = cnt;
    case (pulse_state)
      P_IDLE: if (wr && adr_w == REG_OUT_TIME) pulse_state_n = P_ARMED;
      P_ARMED: begin
        if (wr && adr_w == REG_OUT_TIME) pulse_state_n = P_ARMED;
        else if (time_q == out_time) begin
          pulse_state_n = P_PULSE;
          cnt_n         = (out_width == 8'd0) ? 8'd0 : out_width - 8'd1;
        end
      end
      P_PULSE: begin
        if (wr && adr_w == REG_OUT_TIME) pulse_state_n = P_ARMED;
        else if (cnt == 8'd0)            pulse_state_n = P_IDLE;
        else                             cnt_n = cnt - 8'd1;
      end
      default: pulse_state_n = P_IDLE;
    endcase
  end

  assign out0_o = (pulse_state == P_PULSE);
  assign oen_o  = ~out_en;

  always_comb begin
    rd_data = '0;
    case (adr_w)
      REG_CTRL: begin
        rd_data[CTRL_EN_LSB +: NCH]   = en;
        rd_data[CTRL_FALL_LSB +: NCH] = fall;
        rd_data[CTRL_OUT_EN]          = out_en;
        rd_data[CTRL_RUN]             = run;
      end
      REG_STATUS: begin
        rd_data[NCH-1:0]     = ovf;
        rd_data[16 +: LVL_W] = fifo_level;
        rd_data[31]          = fifo_empty;
      end
      REG_TIME:      rd_data[TS_W-1:0] = time_q;
      REG_EVT_TAG: begin
        rd_data[CHAN_W-1:0] = fifo_empty ? '0 : fifo_dout[DATA_W-1 -: CHAN_W];
        rd_data[31]         = ~fifo_empty;
      end
      REG_EVT_TS:    rd_data[TS_W-1:0] = fifo_empty ? '0 : fifo_dout[TS_W-1:0];
      REG_OUT_TIME:  rd_data[TS_W-1:0] = out_time;
      REG_OUT_WIDTH: rd_data[7:0]      = out_width;
      default: ;
    endcase
  end

endmodule
